// File: rtl/data_memory_pipe.sv
// Pipelined data memory with per-byte write mask, valid/ready request and response ports.
// Optional rd/wr/err statistics counters are built when DATA_MEMORY_PIPE_STATS_EN is defined.
module data_memory_pipe #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DEPTH         = 8,
  parameter int READ_LATENCY  = 2,
  parameter int INIT_IDENTITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_write
`ifdef DATA_MEMORY_PIPE_STATS_EN
  ,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count,
  output logic [15:0]             err_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

  function automatic mem_t f_mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_IDENTITY != 0) ? DATA_WIDTH'(i) : '0;
    end
    return m;
  endfunction

  // Power-up contents only; rst deliberately never touches the array.
  mem_t r_mem = f_mem_init();

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_oor;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_s1_data;

  logic                  r_vld  [READ_LATENCY];
  logic                  r_wr   [READ_LATENCY];
  logic                  r_err  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_data [READ_LATENCY];

  assign w_stall   = r_vld[READ_LATENCY-1] && !rsp_ready;
  assign req_ready = !w_stall;
  // Requests presented while rst is high are dropped so they cannot modify the array.
  assign w_accept  = req_valid && req_ready && !rst;
  assign w_oor     = |(req_addr >> IDX_W);
  assign w_idx     = req_addr[IDX_W-1:0];
  assign w_rd_word = r_mem[w_idx];
  assign w_s1_data = (w_accept && !req_write && !w_oor) ? w_rd_word : '0;

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 1 captures the request; bubbles carry zeroed fields so idle outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld[0]  <= 1'b0;
      r_wr[0]   <= 1'b0;
      r_err[0]  <= 1'b0;
      r_data[0] <= '0;
    end else if (!w_stall) begin
      r_vld[0]  <= w_accept;
      r_wr[0]   <= w_accept && req_write;
      r_err[0]  <= w_accept && w_oor;
      r_data[0] <= w_s1_data;
    end
  end

  generate
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld[gi]  <= 1'b0;
          r_wr[gi]   <= 1'b0;
          r_err[gi]  <= 1'b0;
          r_data[gi] <= '0;
        end else if (!w_stall) begin
          r_vld[gi]  <= r_vld[gi-1];
          r_wr[gi]   <= r_wr[gi-1];
          r_err[gi]  <= r_err[gi-1];
          r_data[gi] <= r_data[gi-1];
        end
      end
    end
  endgenerate

  assign rsp_valid = r_vld[READ_LATENCY-1];
  assign rsp_write = r_wr[READ_LATENCY-1];
  assign rsp_err   = r_err[READ_LATENCY-1];
  assign rsp_rdata = r_data[READ_LATENCY-1];

`ifdef DATA_MEMORY_PIPE_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (w_oor) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end else if (req_write) begin
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end else begin
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;
  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe: vector table, hand-written stall/reset
// sequences and randomized traffic scored against a queue-based reference model.
module tb_data_memory_pipe;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int DEP = 8;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;
  localparam int NV  = 19;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_write;
`ifdef DATA_MEMORY_PIPE_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
  logic [15:0]   err_count;
`endif

  data_memory_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(LAT), .INIT_IDENTITY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_write(rsp_write)
`ifdef DATA_MEMORY_PIPE_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          write;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic          ew;
    logic          ee;
    logic [DW-1:0] ed;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            rsp_count = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEP];
  vec_t          tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a request is out of range when its address is not below DEPTH.
  task automatic model_req(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [NB-1:0] be);
    exp_t e;
    logic oor;
    int   idx;
    oor     = (a >= AW'(DEP));
    idx     = int'(a % AW'(DEP));
    e.write = w;
    e.err   = oor;
    e.rdata = (!w && !oor) ? model_mem[idx] : '0;
    exp_q.push_back(e);
    if (w && !oor) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, score the response, and
  // record an accept that will take effect at the next rising edge.
  task automatic do_cycle(input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [NB-1:0] be,
                          input logic rr, output logic acc);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = rr;
    #1;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=valid(rdata=%0h) required=none", rsp_rdata);
      end else begin
        e = exp_q[0];
        chk("rsp_write", 32'(rsp_write), 32'(e.write));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        if (rr) begin
          void'(exp_q.pop_front());
          rsp_count++;
        end
      end
    end
    acc = v && req_ready;
    if (acc) model_req(w, a, wd, be);
  endtask

  logic          acc;
  int            idx;
  int            cnt0;
  logic [AW-1:0] stall_addr [4];
  logic          rw;
  logic [AW-1:0] ra;

  initial begin
    for (int i = 0; i < DEP; i++) model_mem[i] = DW'(i);
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, AW'(i), 16'h0, 2'b00, 1'b0, 1'b0, DW'(i)};
    tbl[8]  = '{1'b1, 16'h0003, 16'hABCD, 2'b01, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h00CD};
    tbl[10] = '{1'b1, 16'h0003, 16'hABCD, 2'b10, 1'b1, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hABCD};
    tbl[12] = '{1'b0, 16'h0008, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000};
    tbl[13] = '{1'b1, 16'h0100, 16'hFFFF, 2'b11, 1'b1, 1'b1, 16'h0000};
    tbl[14] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};
    tbl[15] = '{1'b1, 16'h0101, 16'hFFFF, 2'b11, 1'b1, 1'b1, 16'h0000};
    tbl[16] = '{1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0001};
    tbl[17] = '{1'b1, 16'h0005, 16'hFFFF, 2'b00, 1'b1, 1'b0, 16'h0000};
    tbl[18] = '{1'b0, 16'h0005, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0005};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_write", 32'(rsp_write), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: back-to-back requests, response of vector c-LAT visible in cycle c
    for (int c = 0; c < NV + LAT + 1; c++) begin
      if (c < NV) do_cycle(1'b1, tbl[c].w, tbl[c].a, tbl[c].wd, tbl[c].be, 1'b1, acc);
      else        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      chk("tbl_req_ready", 32'(req_ready), 32'd1);
      if (c >= LAT && c - LAT < NV) begin
        chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tbl_rsp_write", 32'(rsp_write), 32'(tbl[c-LAT].ew));
        chk("tbl_rsp_err", 32'(rsp_err), 32'(tbl[c-LAT].ee));
        chk("tbl_rsp_rdata", 32'(rsp_rdata), 32'(tbl[c-LAT].ed));
      end else begin
        chk("tbl_rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end

    // Backpressure: 4 reads with rsp_ready low, then release
    stall_addr[0] = 16'd1; stall_addr[1] = 16'd2; stall_addr[2] = 16'd4; stall_addr[3] = 16'd6;
    idx  = 0;
    cnt0 = rsp_count;
    for (int c = 0; c < 6; c++) begin
      do_cycle(idx < 4, 1'b0, stall_addr[idx % 4], '0, '0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_accepts", 32'(idx), 32'(LAT));
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    chk("stall_rsp_rdata", 32'(rsp_rdata), 32'h0001);
    chk("stall_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
      do_cycle(idx < 4, 1'b0, stall_addr[idx % 4], '0, '0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("stall_rsp_total", 32'(rsp_count - cnt0), 32'd4);

    // Reset with two requests in flight
    do_cycle(1'b1, 1'b1, 16'd6, 16'h1234, 2'b11, 1'b1, acc);
    do_cycle(1'b1, 1'b0, 16'd6, '0, '0, 1'b1, acc);
    do_cycle(1'b1, 1'b0, 16'd2, '0, '0, 1'b1, acc);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      chk("postrst_idle", 32'(rsp_valid), 32'd0);
    end
    cnt0 = rsp_count;
    do_cycle(1'b1, 1'b0, 16'd6, '0, '0, 1'b1, acc);
    for (int c = 0; c < LAT + 1; c++) do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk("postrst_read_count", 32'(rsp_count - cnt0), 32'd1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
      do_cycle($urandom_range(0, 3) != 0, rw, ra, DW'($urandom), NB'($urandom),
               $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 50 && (exp_q.size() != 0 || rsp_valid); c++) begin
      do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef DATA_MEMORY_PIPE_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stats_rst_rd", 32'(rd_count), 32'd0);
    chk("stats_rst_wr", 32'(wr_count), 32'd0);
    chk("stats_rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_cycle(1'b1, 1'b0, 16'd0, '0, '0, 1'b1, acc);
    do_cycle(1'b1, 1'b1, 16'd4, 16'h5A5A, 2'b11, 1'b1, acc);
    do_cycle(1'b1, 1'b0, 16'd1, '0, '0, 1'b1, acc);
    do_cycle(1'b1, 1'b0, 16'd9, '0, '0, 1'b1, acc);
    do_cycle(1'b1, 1'b1, 16'd5, 16'hA5A5, 2'b01, 1'b1, acc);
    do_cycle(1'b1, 1'b0, 16'd2, '0, '0, 1'b1, acc);
    for (int c = 0; c < 3; c++) do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk("stats_rd", 32'(rd_count), 32'd3);
    chk("stats_wr", 32'(wr_count), 32'd2);
    chk("stats_err", 32'(err_count), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stats_rst2_rd", 32'(rd_count), 32'd0);
    chk("stats_rst2_wr", 32'(wr_count), 32'd0);
    chk("stats_rst2_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised, pipelined successor to the single-cycle data memory. It accepts one read or write request per cycle over a valid/ready handshake, applies a per-byte write mask and returns in-order responses after a configurable read latency. Response backpressure stalls the whole pipeline. It sits between the MEM stage of the core and the data store.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 16, width of the request word address.
DEPTH, 8, number of words; power of 2, at least 2; IDX_W = log2(DEPTH).
READ_LATENCY, 2, number of pipeline stages from accept to response; legal range 1..4.
INIT_IDENTITY, 1, if 1, word i is initialised to i at time 0; if 0, all words start at 0.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte write enables; bit b covers bits [8b+7:8b]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  address out of range
rsp_write  out  1  echoes req_write of the responding request

Behaviour:
- Accept: a request is accepted when req_valid and req_ready are both high at a rising edge.
- req_ready = !(rsp_valid && !rsp_ready). This is a combinational path from rsp_ready; no other input feeds it.
- Index: idx = req_addr[IDX_W-1:0]. The request is out of range when req_addr[ADDR_WIDTH-1:IDX_W] != 0.
- Write, in range: at the accept edge, each byte b with req_be[b]=1 is updated from req_wdata; the other bytes are kept. The response has rdata 0 and err 0.
- Write, out of range: the array is unchanged. The response has err 1 and rdata 0.
- Write with req_be all 0: the array is unchanged. The response is normal (err 0).
- Read, in range: the array word is sampled at the accept edge. The response has rdata equal to that word and err 0.
- Read, out of range: the response has rdata 0 and err 1.
- Ordering: requests are served strictly in order.
- Read-after-write: a read accepted on any edge after a write's accept edge sees the written bytes, so there is no hazard.
- Pipeline: stage 1 loads at the accept edge. Stage s+1 loads from stage s each non-stalled edge. The last stage drives the rsp_* outputs.
- Latency: a request accepted at edge k produces rsp_valid high after edge k+READ_LATENCY-1. With READ_LATENCY=1, the response appears in the cycle immediately following the accept edge.
- Stall: when rsp_valid=1 and rsp_ready=0, every stage holds and rsp_* stay stable. A non-accepted cycle inserts a bubble (stage valid=0).
- Throughput: with rsp_ready held at 1, one request per cycle is sustained.
- Reset: all stage valids clear to 0. rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0. req_ready=1 during and after reset.
- Reset mid-operation: any request in flight is discarded and no response is ever produced for it. Array contents are not altered by rst.
- Simultaneous events: a response handshake and a new accept on the same edge are legal and both take effect.

Optional Feature:
Macro DATA_MEMORY_PIPE_STATS_EN.
- When defined, three extra output ports exist: rd_count, wr_count and err_count, each 16 bits.
- They count accepted in-range reads, accepted in-range writes and accepted out-of-range requests.
- Each counter increments at the accept edge, saturates at 16'hFFFF and resets to 0 on rst.
- When the macro is undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
1. Reset, INIT_IDENTITY=1, READ_LATENCY=2. Read addresses 0..7 back-to-back with rsp_ready=1 -> rdata 0..7 in order, first rsp_valid one cycle after the second edge, one response per cycle, err=0.
2. Write addr 3 with wdata 16'hABCD, be=2'b01; then read addr 3 on the next cycle -> read rdata 16'h00CD. Then write be=2'b10 and read again -> rdata 16'hABCD.
3. Read addr 16'h0008 -> rdata 0, err=1. Write addr 16'h0100 with data 16'hFFFF, then read addr 0 -> rdata 0 (array unchanged).
4. Issue 4 reads while holding rsp_ready=0 -> req_ready drops once rsp_valid is high and rsp_* hold stable. Release rsp_ready -> all 4 responses arrive in order with none lost or duplicated.
5. Assert rst mid-burst with 2 requests in flight -> rsp_valid goes to 0 immediately, no stale response appears after reset, and a following read of a written address returns the post-write value.
6. With DATA_MEMORY_PIPE_STATS_EN defined: 3 reads, 2 writes and 1 out-of-range request -> rd_count=3, wr_count=2, err_count=1; after rst all three counters read 0.
